// File: rtl/bus_arbiter_pkg.sv
// Shared types and default sizing for the bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SSEL = 2'd1,
    BUSY = 2'd2
  } arb_state_t;

  localparam int unsigned M_NUM_DEFAULT     = 2;
  localparam int unsigned S_NUM_DEFAULT     = 3;
  localparam int unsigned SLAVE_LEN_DEFAULT = 2;

endpackage

// File: rtl/arb_priority_picker.sv
// Picks the first asserted request, scanning upward from ptr with wraparound.
module arb_priority_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int unsigned j;
    logic [IW-1:0] cand;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j    = (32'(ptr) + i) % N;
      cand = IW'(j);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Multi-master bus arbiter: IDLE/SSEL/BUSY FSM with serial slave select, split resume and watchdog.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise priority is fixed with master 0 highest.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned M_NUM     = M_NUM_DEFAULT,
  parameter int unsigned S_NUM     = S_NUM_DEFAULT,
  parameter int unsigned SLAVE_LEN = SLAVE_LEN_DEFAULT,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [M_NUM-1:0]         approval_request,
  input  logic [M_NUM-1:0]         tx_slave_select,
  input  logic [M_NUM-1:0]         trans_done,
  input  logic [S_NUM-1:0]         split_en,
  output logic [M_NUM-1:0]         approval_grant,
  output logic                     arbitor_busy,
  output logic                     bus_busy,
  output logic [S_NUM-1:0]         slave_sel,
  output logic [$clog2(M_NUM)-1:0] master_idx,
  output logic                     addr_err,
  output logic                     timeout
);

  localparam int unsigned IW = $clog2(M_NUM);
  localparam int unsigned BW = (SLAVE_LEN > 1) ? $clog2(SLAVE_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t           state;
  logic [M_NUM-1:0]     req_masked;
  logic [M_NUM-1:0]     pick_grant;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        pick_ptr;
  logic                 pick_valid;
  logic                 split_pending;
  logic [IW-1:0]        split_master;
  logic [S_NUM-1:0]     split_sel;
  logic [SLAVE_LEN-1:0] addr_sh;
  logic [SLAVE_LEN:0]   addr_cat;
  logic [SLAVE_LEN-1:0] addr_next;
  logic [S_NUM-1:0]     addr_onehot;
  logic                 addr_ok;
  logic [BW-1:0]        bit_cnt;
  logic [TW-1:0]        wd_cnt;
  logic                 resume;
  logic                 done_hit;
  logic                 split_hit;
  logic                 wd_hit;

  always_comb begin
    req_masked = approval_request;
    if (split_pending) req_masked[split_master] = 1'b0;
    resume    = split_pending && !(|(split_en & split_sel));
    addr_cat  = {addr_sh, tx_slave_select[master_idx]};
    addr_next = addr_cat[SLAVE_LEN-1:0];
    // Out-of-range addresses shift the one-hot bit off the top, leaving zero.
    addr_onehot = S_NUM'(1) << addr_next;
    addr_ok     = (|addr_onehot) && !(split_pending && (addr_onehot == split_sel));
    done_hit  = trans_done[master_idx];
    split_hit = !split_pending && (|(split_en & slave_sel));
    wd_hit    = (wd_cnt == TW'(TIMEOUT - 1));
  end

  arb_priority_picker #(
    .N  (M_NUM),
    .IW (IW)
  ) u_picker (
    .req   (req_masked),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] last_idx;

  assign last_idx = resume ? split_master : pick_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == IDLE && (resume || pick_valid)) begin
      rr_ptr <= (last_idx == IW'(M_NUM - 1)) ? '0 : last_idx + 1'b1;
    end
  end

  assign pick_ptr = rr_ptr;
`else
  assign pick_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      approval_grant <= '0;
      arbitor_busy   <= 1'b0;
      bus_busy       <= 1'b0;
      slave_sel      <= '0;
      master_idx     <= '0;
      addr_err       <= 1'b0;
      timeout        <= 1'b0;
      split_pending  <= 1'b0;
      split_master   <= '0;
      split_sel      <= '0;
      addr_sh        <= '0;
      bit_cnt        <= '0;
      wd_cnt         <= '0;
    end else begin
      addr_err <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (resume) begin
            approval_grant               <= '0;
            approval_grant[split_master] <= 1'b1;
            master_idx                   <= split_master;
            slave_sel                    <= split_sel;
            split_pending                <= 1'b0;
            wd_cnt                       <= '0;
            arbitor_busy                 <= 1'b1;
            bus_busy                     <= 1'b1;
            state                        <= BUSY;
          end else if (pick_valid) begin
            approval_grant <= pick_grant;
            master_idx     <= pick_idx;
            addr_sh        <= '0;
            bit_cnt        <= '0;
            arbitor_busy   <= 1'b1;
            state          <= SSEL;
          end
        end
        SSEL: begin
          addr_sh <= addr_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(SLAVE_LEN - 1)) begin
            if (addr_ok) begin
              slave_sel <= addr_onehot;
              wd_cnt    <= '0;
              bus_busy  <= 1'b1;
              state     <= BUSY;
            end else begin
              approval_grant <= '0;
              addr_err       <= 1'b1;
              arbitor_busy   <= 1'b0;
              state          <= IDLE;
            end
          end
        end
        BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          // trans_done outranks a split, which outranks the watchdog.
          if (done_hit || split_hit || wd_hit) begin
            approval_grant <= '0;
            slave_sel      <= '0;
            arbitor_busy   <= 1'b0;
            bus_busy       <= 1'b0;
            state          <= IDLE;
          end
          if (!done_hit && split_hit) begin
            split_pending <= 1'b1;
            split_master  <= master_idx;
            split_sel     <= slave_sel;
          end
          if (!done_hit && !split_hit && wd_hit) timeout <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter (M_NUM=2, S_NUM=3, SLAVE_LEN=2, TIMEOUT=16).
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] approval_request;
  logic [1:0] tx_slave_select;
  logic [1:0] trans_done;
  logic [2:0] split_en;
  logic [1:0] approval_grant;
  logic       arbitor_busy;
  logic       bus_busy;
  logic [2:0] slave_sel;
  logic [0:0] master_idx;
  logic       addr_err;
  logic       timeout;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .M_NUM     (2),
    .S_NUM     (3),
    .SLAVE_LEN (2),
    .TIMEOUT   (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .approval_request (approval_request),
    .tx_slave_select  (tx_slave_select),
    .trans_done       (trans_done),
    .split_en         (split_en),
    .approval_grant   (approval_grant),
    .arbitor_busy     (arbitor_busy),
    .bus_busy         (bus_busy),
    .slave_sel        (slave_sel),
    .master_idx       (master_idx),
    .addr_err         (addr_err),
    .timeout          (timeout)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h required <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic send_addr(input int m, input logic [1:0] a);
    tx_slave_select[m] = a[1];
    tick();
    tx_slave_select[m] = a[0];
    tick();
    tx_slave_select = '0;
  endtask

  initial begin
    logic [1:0] w2;
    int         n;

    reset            = 1'b1;
    approval_request = '0;
    tx_slave_select  = '0;
    trans_done       = '0;
    split_en         = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state: {grant, slave_sel, arbitor_busy, bus_busy, addr_err, timeout, master_idx}
    expect_val("reset_outputs", 32'h0);
    check({approval_grant, slave_sel, arbitor_busy, bus_busy, addr_err, timeout, master_idx});

    // Basic transaction: M0 on slave 1, done after 10 BUSY cycles
    approval_request = 2'b01;
    expect_val("s1_grant", 32'b01);
    tick();
    check(approval_grant);
    expect_val("s1_ssel_flags", 32'b10);
    check({arbitor_busy, bus_busy});
    send_addr(0, 2'b01);
    expect_val("s1_slave_sel", 32'b010);
    check(slave_sel);
    approval_request = '0;
    trans_done = 2'b10;
    tick();
    trans_done = '0;
    repeat (8) tick();
    expect_val("s1_hold", {26'b0, 2'b01, 3'b010, 1'b1});
    check({approval_grant, slave_sel, bus_busy});
    trans_done = 2'b01;
    tick();
    trans_done = '0;
    expect_val("s1_release", 32'h0);
    check({approval_grant, slave_sel, arbitor_busy, bus_busy});

    // Simultaneous requests, twice
    reset = 1'b1;
    tick();
    reset = 1'b0;
    approval_request = 2'b11;
    expect_val("s2_first", 32'b01);
    tick();
    check(approval_grant);
    send_addr(0, 2'b00);
    trans_done = 2'b01;
    tick();
    trans_done = '0;
`ifdef ARB_ROUND_ROBIN_EN
    w2 = 2'b10;
`else
    w2 = 2'b01;
`endif
    expect_val("s2_second", {30'b0, w2});
    tick();
    check(approval_grant);
    approval_request = '0;
    send_addr(w2[1] ? 1 : 0, 2'b00);
    trans_done = w2;
    tick();
    trans_done = '0;

    // Invalid slave address
    approval_request = 2'b10;
    expect_val("s3_grant", 32'b10);
    tick();
    check(approval_grant);
    approval_request = '0;
    send_addr(1, 2'b11);
    expect_val("s3_err", {28'b0, 1'b1, 2'b00, 1'b0});
    check({addr_err, approval_grant, bus_busy});
    expect_val("s3_idle", 32'b0);
    check(arbitor_busy);
    tick();
    expect_val("s3_err_pulse", 32'b0);
    check(addr_err);

    // Split and resume
    approval_request = 2'b01;
    expect_val("s4_grant", 32'b01);
    tick();
    check(approval_grant);
    approval_request = '0;
    send_addr(0, 2'b01);
    expect_val("s4_busy", {28'b0, 3'b010, 1'b1});
    check({slave_sel, bus_busy});
    tick();
    tick();
    split_en = 3'b010;
    tick();
    expect_val("s4_split_release", 32'h0);
    check({approval_grant, slave_sel, bus_busy});
    approval_request = 2'b11;
    expect_val("s4_mask", 32'b10);
    tick();
    check(approval_grant);
    approval_request = '0;
    send_addr(1, 2'b00);
    expect_val("s4_m1_sel", 32'b001);
    check(slave_sel);
    trans_done = 2'b10;
    tick();
    trans_done = '0;
    approval_request = 2'b01;
    tick();
    expect_val("s4_wait", 32'b0);
    check({approval_grant, arbitor_busy});
    split_en = '0;
    tick();
    expect_val("s4_resume", {25'b0, 2'b01, 3'b010, 1'b1, 1'b0});
    check({approval_grant, slave_sel, bus_busy, master_idx});
    approval_request = '0;
    trans_done = 2'b01;
    tick();
    trans_done = '0;

    // Watchdog
    approval_request = 2'b10;
    expect_val("s5_grant", 32'b10);
    tick();
    check(approval_grant);
    approval_request = '0;
    send_addr(1, 2'b10);
    expect_val("s5_sel", 32'b100);
    check(slave_sel);
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    expect_val("s5_cycles", 32'd16);
    check(n);
    expect_val("s5_release", 32'h0);
    check({approval_grant, bus_busy, slave_sel});
    tick();
    expect_val("s5_pulse", 32'b0);
    check(timeout);

    // Reset in BUSY, then fresh request; trans_done beats split
    approval_request = 2'b01;
    tick();
    approval_request = '0;
    send_addr(0, 2'b01);
    expect_val("s6_busy", 32'b1);
    check(bus_busy);
    reset = 1'b1;
    tick();
    expect_val("s6_reset", 32'h0);
    check({approval_grant, arbitor_busy, bus_busy, slave_sel, master_idx, addr_err, timeout});
    reset = 1'b0;
    approval_request = 2'b01;
    expect_val("s6_fresh", {28'b0, 2'b01, 1'b1, 1'b0});
    tick();
    check({approval_grant, arbitor_busy, bus_busy});
    send_addr(0, 2'b01);
    split_en   = 3'b010;
    trans_done = 2'b01;
    tick();
    trans_done = '0;
    expect_val("s6_done_wins", 32'h0);
    check({approval_grant, slave_sel});
    expect_val("s6_not_masked", 32'b01);
    tick();
    check(approval_grant);
    approval_request = '0;
    split_en = '0;
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter M_NUM, default 2, number of master ports.
REQ-002 The block SHALL have parameter S_NUM, default 3, number of slave ports.
REQ-003 The block SHALL have parameter SLAVE_LEN, default 2, width of the serial slave-select field.
REQ-004 The block SHALL have parameter TIMEOUT, default 4096, maximum cycles in BUSY before forced release.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 Ports SHALL be:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- approval_request  in  M_NUM  per-master bus request
- tx_slave_select  in  M_NUM  per-master serial slave address, MSB first
- trans_done  in  M_NUM  per-master end-of-transaction pulse
- split_en  in  S_NUM  per-slave split request
- approval_grant  out  M_NUM  one-hot grant
- arbitor_busy  out  1  arbiter not IDLE
- bus_busy  out  1  data phase active
- slave_sel  out  S_NUM  one-hot slave enable
- master_idx  out  $clog2(M_NUM)  currently granted master, drives bus mux
- addr_err  out  1  one-cycle pulse: invalid or conflicting slave address
- timeout  out  1  one-cycle pulse: forced release

Function
REQ-007 The FSM SHALL have states IDLE, SSEL, BUSY.
REQ-008 arbitor_busy SHALL be 1 in SSEL and BUSY; bus_busy SHALL be 1 only in BUSY.
REQ-009 IDLE, with any unmasked request: the winner SHALL be registered, and approval_grant[winner] SHALL assert on the next edge, entering SSEL.
REQ-010 SSEL: tx_slave_select[winner] SHALL be sampled on SLAVE_LEN consecutive cycles, starting the cycle after grant assertion, MSB first.
REQ-011 After the last bit, a decoded index < S_NUM that is not the split-pending slave: next state BUSY, slave_sel one-hot of that index.
- Otherwise: grant drops, addr_err pulses, next state IDLE.
REQ-012 BUSY: grant and slave_sel SHALL be held until trans_done[master_idx]=1.
- Grant, slave_sel and bus_busy then clear on the next edge; next state IDLE.
- trans_done from non-granted masters SHALL be ignored.
REQ-013 BUSY with split_en[selected slave]=1 and no split pending: the master/slave pair SHALL be saved, grant and slave_sel drop, next state IDLE.
REQ-014 While a split is pending, the split master's request SHALL be masked.
REQ-015 In IDLE, if the saved slave's split_en=0, the split master SHALL win over all requesters and enter BUSY directly with the saved slave_sel, skipping SSEL; the pending flag then clears.
REQ-016 Split while another split is pending: the transaction SHALL continue as normal BUSY (split ignored).
REQ-017 BUSY watchdog: the counter SHALL reset on BUSY entry; on reaching TIMEOUT-1 without trans_done, the arbiter SHALL release as in REQ-012 and pulse timeout.
REQ-018 Requester withdrawal (approval_request drop) during SSEL/BUSY SHALL NOT abort the transaction.
REQ-019 Simultaneous trans_done and split_en in BUSY: trans_done SHALL take precedence.

Reset
REQ-020 On reset, the state SHALL be IDLE, all outputs 0, split-pending flag cleared, counters 0, round-robin pointer 0, effective at the next edge, including mid-transaction.

Configuration
REQ-021 With macro ARB_ROUND_ROBIN_EN defined, priority SHALL rotate: the last granted master becomes lowest priority.
REQ-022 Without ARB_ROUND_ROBIN_EN, priority SHALL be fixed: index 0 highest.
REQ-023 The split-resume priority of REQ-015 SHALL apply in both modes.

Structure
REQ-024 Package bus_arbiter_pkg SHALL hold the state enum and the default M_NUM/S_NUM/SLAVE_LEN constants.
REQ-025 Winner selection SHALL be a sub-module arb_priority_picker (request vector + pointer -> one-hot and index).

Verification
REQ-026 The bench SHALL cover these scenarios:
- M0 request, serial slave 2'b01, trans_done after 10 cycles -> grant[0] after 1 cycle; slave_sel=3'b010 after 2 address cycles; all clear 1 cycle after trans_done.
- M0 and M1 request together, twice, fixed mode -> M0 wins both; with ARB_ROUND_ROBIN_EN -> M0 then M1.
- Slave address 2'b11 with S_NUM=3 -> addr_err pulse, grant drops, bus_busy stays 0.
- M0 on slave 1 raises split_en; M1 then transacts on slave 0; split_en falls -> M0 regranted directly into BUSY with slave_sel=3'b010.
- No trans_done for TIMEOUT=16 cycles -> timeout pulse at cycle 16 of BUSY, all grants 0.
- reset asserted in BUSY -> all outputs 0 at the next edge; a fresh request then starts from IDLE.
